// File: rtl/send_stream_fifo.sv
// send_stream_fifo: FIFO-buffered serialiser; optional even parity bit when STREAM_PARITY_EN is defined.
// Latency: a write into an empty FIFO at cycle N is popped at N+1, and its first bit shows at N+2.
// Backpressure: wr_ready = not-full; writes while full are dropped.
module send_stream_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit IDLE_LVL     = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic                   datastream,
  output logic                   busy,
  output logic                   word_done,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef STREAM_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]    IDX_LAST = 6'(NBITS - 1);
  localparam logic [5:0]    GAP_LAST = 6'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam bit            HAS_GAP  = (GAP_BITS > 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     bit_cnt;
  logic [5:0]        bit_idx;
  logic [NBITS-1:0]  shreg;
  logic [NBITS-1:0]  seq;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] ordered;
  logic              push;
  logic              pop;
  logic              bit_end;
  logic              word_end;
  logic              gap_end;

  assign wr_ready = (level != FULL);
  assign push     = wr_valid && wr_ready;
  assign head     = mem[rd_ptr];

  // Arrange the head word in transmit order (first bit at the top), add parity, decide whether to pop.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ordered[DATA_W-1-i] = MSB_FIRST ? head[DATA_W-1-i] : head[i];
    end
`ifdef STREAM_PARITY_EN
    seq = {ordered, ^head};
`else
    seq = ordered;
`endif
    bit_end  = (bit_cnt == CNT_LAST);
    word_end = (state == SHIFT) && bit_end && (bit_idx == IDX_LAST);
    gap_end  = (state == GAP) && bit_end && (bit_idx == GAP_LAST);
    pop      = (level != '0) && ((state == IDLE) || gap_end || (word_end && !HAS_GAP));
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Serialiser FSM; outputs registered, pop takes priority so a freed slot is reused with no idle cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      datastream <= IDLE_LVL;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (pop) begin
        state      <= SHIFT;
        busy       <= 1'b1;
        bit_cnt    <= '0;
        bit_idx    <= '0;
        datastream <= seq[NBITS-1];
        shreg      <= seq << 1;
        word_done  <= (CLKS_PER_BIT == 1) && (NBITS == 1);
      end else begin
        case (state)
          SHIFT: begin
            if (!bit_end) begin
              bit_cnt   <= bit_cnt + 1'b1;
              word_done <= (CW'(bit_cnt + 1'b1) == CNT_LAST) && (bit_idx == IDX_LAST);
            end else if (bit_idx != IDX_LAST) begin
              bit_cnt    <= '0;
              bit_idx    <= bit_idx + 1'b1;
              datastream <= shreg[NBITS-1];
              shreg      <= shreg << 1;
              word_done  <= (CLKS_PER_BIT == 1) && (6'(bit_idx + 1'b1) == IDX_LAST);
            end else begin
              bit_cnt    <= '0;
              bit_idx    <= '0;
              datastream <= IDLE_LVL;
              if (HAS_GAP) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          GAP: begin
            if (!bit_end) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_idx != GAP_LAST) begin
              bit_cnt <= '0;
              bit_idx <= bit_idx + 1'b1;
            end else begin
              bit_cnt <= '0;
              bit_idx <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end
            datastream <= IDLE_LVL;
          end
          default: begin
            datastream <= IDLE_LVL;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_send_stream_fifo.sv
// tb_send_stream_fifo: random traffic against a timeline model of the serialiser plus directed cases.
// Latency: words are expected to start two cycles after their write when the line is free.
// Backpressure: acceptance is predicted from the model's occupancy and compared with wr_ready.
module tb_send_stream_fifo;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int GAP   = 1;
  localparam int MAXC  = 12000;
`ifdef STREAM_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, datastream, busy, word_done;
  logic [4:0] level;

  logic       reset2 = 1'b0;
  logic       wr_valid2 = 1'b0;
  logic [7:0] wr_data2 = '0;
  logic       wr_ready2, datastream2, busy2, word_done2;
  logic [2:0] level2;

  send_stream_fifo u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .datastream(datastream), .busy(busy), .word_done(word_done), .level(level)
  );

  send_stream_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(1), .GAP_BITS(0), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_lsb (
    .clk(clk), .reset(reset2), .wr_valid(wr_valid2), .wr_data(wr_data2), .wr_ready(wr_ready2),
    .datastream(datastream2), .busy(busy2), .word_done(word_done2), .level(level2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int e; logic [7:0] d; } rec_t;
  typedef struct { int wc; int pc; } inrec_t;
  rec_t   sb[$];
  inrec_t inq[$];
  bit     exp_line [MAXC];
  bit     exp_busy [MAXC];
  logic   seen     [MAXC];
  int     lprev = -1;
  int     last_s = 0;
  logic   rdy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Bits in transmit order: index 0 goes out first, parity (if any) last.
  function automatic logic [8:0] word_bits(input logic [7:0] d, input bit msb);
    logic [8:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = msb ? d[7-i] : d[i];
`ifdef STREAM_PARITY_EN
    b[8] = ^d;
`endif
    return b;
  endfunction

  // Schedule an accepted word: popped when the line frees up, then NB bit-times plus the gap.
  task automatic accept(input int n, input logic [7:0] d);
    int p, s, e, l;
    logic [8:0] wb;
    rec_t r;
    inrec_t q;
    p = (n + 1 > lprev) ? n + 1 : lprev;
    s = p + 1;
    e = s + NB * CPB - 1;
    l = e + GAP * CPB;
    lprev = l;
    last_s = s;
    wb = word_bits(d, 1'b1);
    for (int c = s; c <= l && c < MAXC; c++) begin
      exp_busy[c] = 1'b1;
      exp_line[c] = (c <= e) ? wb[(c - s) / CPB] : 1'b0;
    end
    r.e = e; r.d = d; sb.push_back(r);
    q.wc = n; q.pc = p; inq.push_back(q);
  endtask

  task automatic flush(input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      exp_line[c] = 1'b0;
      exp_busy[c] = 1'b0;
    end
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].e > r) sb.delete(i);
    inq.delete();
    lprev = -1;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rst);
    int lvl;
    inrec_t q;
    @(negedge clk);
    while (inq.size() > 0 && inq[0].pc < cyc) q = inq.pop_front();
    lvl = 0;
    foreach (inq[i]) if (inq[i].wc < cyc) lvl++;
    if (cyc >= 1) begin
      chk("level", 32'(level), 32'(lvl));
      chk("wr_ready", 32'(wr_ready), 32'(lvl < DEPTH));
    end
    rdy_seen = wr_ready;
    reset    = !rst;
    wr_valid = v && !rst;
    wr_data  = d;
    if (rst) flush(cyc);
    else if (v && lvl < DEPTH) accept(cyc, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (cyc <= lprev + 2 && n < 3000) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: line and busy every cycle; on each word_done, pop the scoreboard and rebuild the word.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      seen[cyc] = datastream;
      chk("datastream", 32'(datastream), 32'(exp_line[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      if (word_done !== 1'b0) begin
        if (sb.size() == 0) begin
          chk("word_done_spurious", 32'(word_done), 32'd0);
        end else begin
          rec_t r;
          logic [8:0] wb, got;
          bit hold;
          int s;
          r = sb.pop_front();
          chk("word_done_cycle", 32'(cyc), 32'(r.e));
          wb = word_bits(r.d, 1'b1);
          got = '0;
          hold = 1'b1;
          s = cyc - NB * CPB + 1;
          if (s >= 1) begin
            for (int b = 0; b < NB; b++) begin
              got[b] = seen[s + b * CPB];
              for (int k = 1; k < CPB; k++) if (seen[s + b * CPB + k] !== got[b]) hold = 1'b0;
            end
          end
          chk("word_bits", 32'(got), 32'(wb));
          chk("bit_hold", 32'(hold), 32'd1);
        end
      end
    end
  end

  // LSB-first, no gap, one cycle per bit: two back-to-back words must run contiguously.
  initial begin
    logic [8:0] wa, wb;
    int wd;
    wa = word_bits(8'h01, 1'b0);
    wb = word_bits(8'h80, 1'b0);
    wd = 0;
    repeat (3) @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk);
    wr_valid2 = 1'b1; wr_data2 = 8'h01;
    @(negedge clk);
    wr_data2 = 8'h80;
    @(negedge clk);
    wr_valid2 = 1'b0;
    for (int i = 0; i < 2 * NB; i++) begin
      chk("lsb_stream_bit", 32'(datastream2), 32'((i < NB) ? wa[i] : wb[i - NB]));
      if (word_done2 === 1'b1) wd++;
      @(negedge clk);
    end
    chk("lsb_word_done_count", 32'(wd), 32'd2);
    chk("lsb_idle_line", 32'(datastream2), 32'd0);
    chk("lsb_idle_busy", 32'(busy2), 32'd0);
    chk("lsb_level", 32'(level2), 32'd0);
    chk("lsb_ready", 32'(wr_ready2), 32'd1);
  end

  initial begin
    int acc, s0, pct, seg;
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Single word from idle.
    step(1'b1, 8'hA5, 1'b0);
    drain();

    // Twenty back-to-back writes from idle: only 17 fit (16 queued plus one in flight).
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      if (rdy_seen === 1'b1) acc++;
    end
    chk("burst_accepts", 32'(acc), 32'd17);
    drain();

    // Random traffic with heavy, light and medium phases.
    for (int i = 0; i < 1500; i++) begin
      seg = (i / 300) % 3;
      pct = (seg == 0) ? 90 : ((seg == 1) ? 10 : 40);
      step($urandom_range(0, 99) < pct, 8'($urandom), 1'b0);
    end
    drain();

    // Reset during bit 3 of a word with five words queued behind it.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      if (i == 0) s0 = last_s;
    end
    while (cyc < s0 + 3 * CPB) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (40) step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 300; i++) step($urandom_range(0, 99) < 50, 8'($urandom), 1'b0);
    drain();
    repeat (4) step(1'b0, 8'h00, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
